serializador_matriz: RTL and testbench

- Write-back end of the coprocessor ULA datapath.
- Takes one packed 5x5 matrix of 8-bit elements, the same 200-bit row-major format the ULA operators produce and consume, and streams it into data memory one element per accepted write.
- Optional on-the-fly transposition and an active sub-matrix size (1..5) let the controller store NxN results compactly without a separate transpose pass.
- Sits between the ULA result register and the memory write port.

---
 rtl/matriz_pkg.sv | 18 +
 rtl/seletor_elemento.sv | 15 +
 rtl/serializador_matriz.sv | 99 +++++++++
 tb/tb_serializador_matriz.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// matriz_pkg: shared constants, FSM state type and element-addressing helpers for the matrix datapath
// Provides ELEM_W/DIM/MAT_W/ADDR_W, estado_t {IDLE, WRITE, DONE},
// offset_elem(l, c) = bit offset of element (l,c) in the packed row-major matrix,
// clamp_n(t) = active dimension with 0 and values above DIM mapped to DIM.
package matriz_pkg;
    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int MAT_W  = DIM * DIM * ELEM_W;
    localparam int ADDR_W = 9;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} estado_t;
    // 8 bits cover the largest offset (192) inside the 200-bit matrix exactly
    function automatic logic [7:0] offset_elem(input logic [2:0] l, input logic [2:0] c);
        return 8'(DIM * ELEM_W) * {5'b0, l} + 8'(ELEM_W) * {5'b0, c};
    endfunction
    function automatic logic [2:0] clamp_n(input logic [2:0] t);
        return (t == 3'd0 || t > 3'(DIM)) ? 3'(DIM) : t;
    endfunction
endpackage

// File: rtl/seletor_elemento.sv
// seletor_elemento: combinational pick of one element from a packed matrix, optionally transposed
// Ports: matriz_i (packed matrix), lin_i/col_i (element coordinates), transpor_i (1 = read (col,lin)),
//        elem_o (selected element).
module seletor_elemento
    import matriz_pkg::*;
(
    input  logic [MAT_W-1:0]  matriz_i,
    input  logic [2:0]        lin_i,
    input  logic [2:0]        col_i,
    input  logic              transpor_i,
    output logic [ELEM_W-1:0] elem_o
);
    assign elem_o = transpor_i ? matriz_i[offset_elem(col_i, lin_i) +: ELEM_W]
                               : matriz_i[offset_elem(lin_i, col_i) +: ELEM_W];
endmodule

// File: rtl/serializador_matriz.sv
// serializador_matriz: streams the NxN top-left block of a captured matrix into memory, one element per accepted write
// Ports: clk/rst (async active-high), start (sampled in IDLE), matriz/base_addr/tamanho/transpor (captured on start),
//        mem_wr_en/mem_addr/mem_wdata (registered write request), mem_ready (write accepted),
//        busy (WRITE or DONE), done (one-cycle completion pulse).
module serializador_matriz
    import matriz_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MAT_W-1:0]  matriz,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [2:0]        tamanho,
    input  logic              transpor,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ELEM_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);
    estado_t           state_q;
    logic [MAT_W-1:0]  mat_q;
    logic [ADDR_W-1:0] base_q, addr_q, addr_d;
    logic [2:0]        n_q, lin_q, col_q, lin_d, col_d;
    logic              transp_q, wr_q, idle, ultima_col, ultimo;
    logic [5:0]        prod;
    logic [ELEM_W-1:0] wdata_q, elem;

    // lin_d/col_d are the coordinates of the element presented after the current event:
    // (0,0) when starting from IDLE, otherwise the successor of the element just accepted.
    always_comb begin
        idle       = state_q == IDLE;
        ultima_col = col_q == n_q - 3'd1;
        ultimo     = ultima_col && lin_q == n_q - 3'd1;
        col_d      = (idle || ultima_col) ? 3'd0 : col_q + 3'd1;
        lin_d      = idle ? 3'd0 : ultima_col ? lin_q + 3'd1 : lin_q;
        prod       = {3'b0, lin_d} * {3'b0, n_q};
        addr_d     = idle ? base_addr : base_q + ADDR_W'(prod) + ADDR_W'(col_d);
    end

    // In IDLE the first element comes straight from the inputs being captured
    seletor_elemento u_sel (
        .matriz_i   (idle ? matriz : mat_q),
        .lin_i      (lin_d),
        .col_i      (col_d),
        .transpor_i (idle ? transpor : transp_q),
        .elem_o     (elem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mat_q    <= '0;
            base_q   <= '0;
            n_q      <= '0;
            transp_q <= 1'b0;
            lin_q    <= '0;
            col_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= WRITE;
                    mat_q    <= matriz;
                    base_q   <= base_addr;
                    transp_q <= transpor;
                    n_q      <= clamp_n(tamanho);
                    lin_q    <= '0;
                    col_q    <= '0;
                    wr_q     <= 1'b1;
                    addr_q   <= addr_d;
                    wdata_q  <= elem;
                end
                WRITE: if (mem_ready) begin
                    if (ultimo) begin
                        state_q <= DONE;
                        wr_q    <= 1'b0;
                    end else begin
                        lin_q   <= lin_d;
                        col_q   <= col_d;
                        addr_q  <= addr_d;
                        wdata_q <= elem;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_wr_en = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_serializador_matriz.sv
// tb_serializador_matriz: directed checks of the matrix write-back serializer
module tb_serializador_matriz;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [199:0] matriz = '0;
    logic [8:0]   base_addr = '0;
    logic [2:0]   tamanho = '0;
    logic         transpor = 1'b0;
    logic         mem_wr_en;
    logic [8:0]   mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_ready = 1'b1;
    logic         busy;
    logic         done;
    logic [199:0] mat;
    logic [8:0]   wa [0:24];
    logic [7:0]   wd [0:24];
    int           errors = 0;
    int           checks = 0;

    serializador_matriz dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .matriz    (matriz),
        .base_addr (base_addr),
        .tamanho   (tamanho),
        .transpor  (transpor),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle k counts from the start edge; outputs are sampled at the falling edge of cycle k.
    // pat gives mem_ready for cycles 1,2,3,4 (LSB first), repeating.
    task automatic transferir(input logic [8:0] base, input logic [2:0] tam, input logic tr,
                              input logic [3:0] pat, input int n, input int exp_done, input int abort_at);
        int nw, done_k;
        logic stall, abortado;
        logic [8:0] pa, ea;
        logic [7:0] pd, ed;
        nw = 0;
        done_k = 0;
        stall = 1'b0;
        abortado = 1'b0;
        @(negedge clk);
        matriz = mat;
        base_addr = base;
        tamanho = tam;
        transpor = tr;
        mem_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        matriz = '1;
        base_addr = 9'h000;
        tamanho = 3'd1;
        transpor = ~tr;
        for (int k = 1; k <= 120 && done_k == 0 && !abortado; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (abort_at != 0 && nw == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_wr_en", mem_wr_en, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_wdata", mem_wdata, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                abortado = 1'b1;
            end else begin
                chk("busy_active", busy, 1);
                if (stall) begin
                    chk("hold_addr", mem_addr, pa);
                    chk("hold_data", mem_wdata, pd);
                end
                if (done) begin
                    done_k = k;
                    chk("done_no_wr", mem_wr_en, 0);
                end
                mem_ready = pat[(k-1)%4];
                stall = mem_wr_en && !mem_ready;
                pa = mem_addr;
                pd = mem_wdata;
                if (mem_wr_en && mem_ready) begin
                    ea = base + 9'(nw);
                    ed = tr ? 8'(10 * (nw % n) + nw / n) : 8'(10 * (nw / n) + nw % n);
                    chk("wr_addr", mem_addr, ea);
                    chk("wr_data", mem_wdata, ed);
                    if (nw < 25) begin
                        wa[nw] = mem_addr;
                        wd[nw] = mem_wdata;
                    end
                    nw++;
                end
            end
        end
        mem_ready = 1'b1;
        if (!abortado) begin
            chk("n_writes", nw, n * n);
            chk("done_cycle", done_k, exp_done);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_wr_en", mem_wr_en, 0);
        end
    endtask

    initial begin
        for (int l = 0; l < 5; l++)
            for (int c = 0; c < 5; c++)
                mat[40*l + 8*c +: 8] = 8'(10*l + c);
        @(negedge clk);
        chk("reset_wr_en", mem_wr_en, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        transferir(9'h040, 3'd5, 1'b0, 4'b1111, 5, 26, 0);
        chk("n5_last_addr", wa[24], 9'h058);
        chk("n5_row1_data", wd[5], 8'h0A);
        chk("n5_last_data", wd[24], 8'h2C);

        transferir(9'h040, 3'd5, 1'b1, 4'b1111, 5, 26, 0);
        chk("tr_addr041", wa[1], 9'h041);
        chk("tr_data041", wd[1], 8'h0A);
        chk("tr_addr045", wa[5], 9'h045);
        chk("tr_data045", wd[5], 8'h01);
        chk("tr_data058", wd[24], 8'h2C);

        transferir(9'h100, 3'd3, 1'b0, 4'b1111, 3, 10, 0);
        chk("n3_data3", wd[3], 8'h0A);
        chk("n3_addr8", wa[8], 9'h108);
        chk("n3_data8", wd[8], 8'h16);

        transferir(9'h040, 3'd0, 1'b0, 4'b1111, 5, 26, 0);
        transferir(9'h040, 3'd7, 1'b0, 4'b1111, 5, 26, 0);

        transferir(9'h000, 3'd3, 1'b0, 4'b1001, 3, 18, 0);

        transferir(9'h1FE, 3'd2, 1'b0, 4'b1111, 2, 0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_wr_en", mem_wr_en, 0);
            chk("post_rst_busy", busy, 0);
        end

        transferir(9'h1FE, 3'd2, 1'b0, 4'b1111, 2, 5, 0);
        chk("wrap_addr0", wa[0], 9'h1FE);
        chk("wrap_addr1", wa[1], 9'h1FF);
        chk("wrap_addr2", wa[2], 9'h000);
        chk("wrap_addr3", wa[3], 9'h001);
        chk("wrap_data0", wd[0], 8'h00);
        chk("wrap_data3", wd[3], 8'h0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
